// File: rtl/seg_scan_mux.sv
// Time-multiplexed BCD digit scanner with double-buffered frames and leading-zero blanking.
// All outputs are registered copies of values decoded from the next-state of the scan counters.
module seg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  commit
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [CW-1:0]            cnt, cnt_nx;
    logic [IW-1:0]            idx, idx_nx;
    logic [DIGITS-1:0][3:0]   disp, disp_nx;
    logic [DIGITS-1:0]        disp_dp, disp_dp_nx;
    logic [DIGITS-1:0][3:0]   shd, shd_nx;
    logic [DIGITS-1:0]        shd_dp, shd_dp_nx;
    logic                     pending, pending_nx;
    logic [DIGITS-1:0][3:0]   din;
    logic                     tick, boundary;
    logic                     commit_nx;
    logic [DIGITS-1:0]        lz_run;
    logic                     an_on;
    logic [3:0]               bcd_nx;
    logic [DIGITS-1:0]        an_nx;
    logic                     dp_nx;

    assign din = digits_in;

    always_comb begin
        tick     = (cnt == CNT_MAX);
        boundary = tick && (idx == IDX_MAX);
        cnt_nx   = tick ? '0 : cnt + 1'b1;
        idx_nx   = idx;
        if (tick) begin
            idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end

        disp_nx    = disp;
        disp_dp_nx = disp_dp;
        shd_nx     = shd;
        shd_dp_nx  = shd_dp;
        pending_nx = pending;
        commit_nx  = 1'b0;

        // A load landing on the boundary bypasses the shadow so it is never one frame late.
        if (load && boundary) begin
            disp_nx    = din;
            disp_dp_nx = dp_in;
            pending_nx = 1'b0;
            commit_nx  = 1'b1;
        end else if (load) begin
            shd_nx     = din;
            shd_dp_nx  = dp_in;
            pending_nx = 1'b1;
        end else if (boundary && pending) begin
            disp_nx    = shd;
            disp_dp_nx = shd_dp;
            pending_nx = 1'b0;
            commit_nx  = 1'b1;
        end
    end

    // lz_run[i] is set when digit i and every more-significant digit are zero.
    always_comb begin
        lz_run = '0;
        lz_run[DIGITS-1] = (disp_nx[DIGITS-1] == 4'h0);
        for (int unsigned j = 0; j < DIGITS - 1; j++) begin
            lz_run[DIGITS-2-j] = lz_run[DIGITS-1-j] && (disp_nx[DIGITS-2-j] == 4'h0);
        end
    end

    always_comb begin
        an_on  = (cnt_nx >= CNT_BLANK);
        bcd_nx = disp_nx[idx_nx];
        if (blank_lz && (idx_nx != '0) && lz_run[idx_nx]) begin
            bcd_nx = 4'hF;
        end
        an_nx = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (an_on && (idx_nx == IW'(i))) begin
                an_nx[i] = 1'b0;
            end
        end
        dp_nx = an_on ? ~disp_dp_nx[idx_nx] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            disp    <= '1;
            disp_dp <= '0;
            shd     <= '0;
            shd_dp  <= '0;
            pending <= 1'b0;
            bcd_out <= 4'hF;
            an_n    <= '1;
            dp_n    <= 1'b1;
            commit  <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            disp    <= disp_nx;
            disp_dp <= disp_dp_nx;
            shd     <= shd_nx;
            shd_dp  <= shd_dp_nx;
            pending <= pending_nx;
            bcd_out <= bcd_nx;
            an_n    <= an_nx;
            dp_n    <= dp_nx;
            commit  <= commit_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus random loads against a
// frame-level model driven by the cycle number since reset release.
module tb_seg_scan_mux;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FRAME = D * RD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load;
    logic [4*D-1:0]  digits_in;
    logic [D-1:0]    dp_in;
    logic            blank_lz;
    logic [3:0]      bcd_out;
    logic [D-1:0]    an_n;
    logic            dp_n;
    logic            commit;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: cycle count since release, displayed frame, shadow frame.
    int unsigned n;
    logic [15:0] m_frame;
    logic [3:0]  m_dp;
    logic [15:0] m_shd;
    logic [3:0]  m_shd_dp;
    logic        m_pending;
    logic        m_commit;
    logic        m_blz;

    seg_scan_mux #(
        .DIGITS      (D),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .digits_in(digits_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .bcd_out  (bcd_out),
        .an_n     (an_n),
        .dp_n     (dp_n),
        .commit   (commit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_frame   = 16'hFFFF;
        m_dp      = '0;
        m_shd     = '0;
        m_shd_dp  = '0;
        m_pending = 1'b0;
        m_commit  = 1'b0;
        m_blz     = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_bcd", 32'(bcd_out), 32'hF);
        check_val("rst_an", 32'(an_n), 32'hF);
        check_val("rst_dp", 32'(dp_n), 32'h1);
        check_val("rst_commit", 32'(commit), 32'h0);
    endtask

    // Check the current cycle, advance the model using the driven inputs, move to the next cycle.
    task automatic tick();
        int unsigned c, s;
        logic [3:0]  e_an, e_bcd;
        logic        e_dp, blanked;
        logic [15:0] upper;
        c       = n % RD;
        s       = (n / RD) % D;
        e_an    = (c >= BC) ? ~(4'b0001 << s) : 4'hF;
        upper   = m_frame >> (4 * s);
        blanked = m_blz && (s >= 1) && (upper == 16'h0);
        e_bcd   = blanked ? 4'hF : upper[3:0];
        e_dp    = (c >= BC) ? ~m_dp[s] : 1'b1;
        check_val("an_n", 32'(an_n), 32'(e_an));
        check_val("bcd_out", 32'(bcd_out), 32'(e_bcd));
        check_val("dp_n", 32'(dp_n), 32'(e_dp));
        check_val("commit", 32'(commit), 32'(m_commit));

        m_commit = 1'b0;
        if (load && (n % FRAME == FRAME - 1)) begin
            m_frame   = digits_in;
            m_dp      = dp_in;
            m_pending = 1'b0;
            m_commit  = 1'b1;
        end else if (load) begin
            m_shd     = digits_in;
            m_shd_dp  = dp_in;
            m_pending = 1'b1;
        end else if (m_pending && (n % FRAME == FRAME - 1)) begin
            m_frame   = m_shd;
            m_dp      = m_shd_dp;
            m_pending = 1'b0;
            m_commit  = 1'b1;
        end
        m_blz = blank_lz;
        n++;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) tick();
    endtask

    task automatic run_to(input int unsigned phase);
        while (n % FRAME != phase) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
        load      = 1'b1;
        digits_in = d;
        dp_in     = dpv;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_lz  = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Scan sequence from reset with the blank display.
        idle(2 * FRAME);

        // Mid-frame load during slot 1, committed at the next boundary.
        run_to(5);
        do_load(16'h1234, 4'b0100);
        idle(2 * FRAME);

        // Leading-zero blanking on a sparse value.
        blank_lz = 1'b1;
        run_to(6);
        do_load(16'h0050, 4'b0000);
        idle(2 * FRAME);

        // All-zero frame, blanked then unblanked.
        do_load(16'h0000, 4'b0001);
        idle(2 * FRAME);
        blank_lz = 1'b0;
        idle(2 * FRAME);

        // Load mid-frame, then a bypass load exactly on the boundary.
        run_to(3);
        do_load(16'h1111, 4'b1111);
        run_to(FRAME - 1);
        do_load(16'h9876, 4'b0010);
        idle(2 * FRAME);

        // Reset asserted in slot 2 while a frame is pending.
        run_to(5);
        do_load(16'h4321, 4'b0001);
        run_to(9);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(3 * FRAME);

        // Random loads, including ones that fall on boundaries, with blank_lz toggling.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 11) == 0) begin
                logic [15:0] f;
                for (int k = 0; k < D; k++) begin
                    f[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                do_load(f, 4'($urandom_range(0, 15)));
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
